aes_encrypt_sequencer: RTL and testbench
========================================

Name: aes_encrypt_sequencer

Overview:
Iterative AES-128 encryption engine controller. It accepts a plaintext block and a cipher key over a valid/ready handshake. It then sequences one full round per clock through a local round datapath and on-the-fly key schedule, and presents the ciphertext over a second valid/ready handshake. It sits between the host-facing block buffer and the output stage, and it is the only consumer of the shared forward S-box table for encryption.

Parameters:
- ROUNDS, 10: number of cipher rounds after the initial AddRoundKey. Only 10 (AES-128) is supported; any other value is an elaboration error.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  plaintext/key present
- in_ready  out  1  sequencer can accept a block
- plaintext  in  state_t  input block; byte 0 = first byte of the 128-bit block
- key  in  roundKey_t  cipher key, same byte order
- out_valid  out  1  ciphertext present
- out_ready  in  1  downstream accepts ciphertext
- ciphertext  out  state_t  result block
- busy  out  1  high in ROUND or DONE
- round_num  out  4  current round counter, for debug

Behaviour:
- One clock. Reset is asynchronous and active-low, named reset_n; clock is named clock.
- Reset values: FSM=IDLE, in_ready=1, out_valid=0, busy=0, round_num=0, state and round-key registers=0, ciphertext=0.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid and in_ready are both high at an edge, the block registers state<=plaintext XOR key, registers rk<=key, sets round_num<=1, and moves to ROUND.
  - plaintext and key are sampled only on that edge; they are don't-care otherwise.
- ROUND:
  - in_ready=0, and in_valid is ignored.
  - Each cycle, rk_next is computed from rk with rcon[round_num], where rcon = 01,02,04,08,10,20,40,80,1B,36.
  - Key schedule: words w0..w3 are bytes 4c..4c+3. temp = SubWord(RotWord(w3)) XOR {rcon,00,00,00}. Then w0'=w0^temp, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
  - Round function: state <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), rk_next). rk <= rk_next.
  - When round_num==ROUNDS, MixColumns is skipped, and the FSM moves to DONE with out_valid<=1. Otherwise round_num increments.
- ShiftRows: new[r+4c] = old[r+4((c+r) mod 4)].
- MixColumns: standard GF(2^8) with polynomial 0x11B; xtime(b) = (b<<1) XOR (b[7]?1B:00).
- SubBytes indexes the package sbox as sbox[b[7:4]][b[3:0]].
- DONE:
  - out_valid=1, and ciphertext=state held stable until the out_ready edge.
  - On out_valid && out_ready, the FSM returns to IDLE: out_valid<=0, round_num<=0.
  - ciphertext keeps its last value; it is don't-care when out_valid=0.
- Latency: 10 cycles from the accepting edge to the out_valid rising edge. Minimum block period is 12 cycles, because in_ready is high only in IDLE. No acceptance occurs in DONE, even if out_ready is high in the same cycle.
- Backpressure: out_ready may stay low indefinitely. Outputs must not change while stalled.
- Reset mid-operation: asserting reset_n=0 in any state immediately forces the reset values. The in-flight block is discarded and no out_valid pulse occurs.
- There is no combinational path from in_valid or out_ready to in_ready or out_valid; all handshake outputs decode from registers.

Decomposition:
- Shared package additions:
  - rcon_t and the RCON[1:10] constant table.
  - the aesSeqState_t enum {IDLE, ROUND, DONE}.
  - functions xtime, subBytes, shiftRows, mixColumns, addRoundKey operating on state_t. These reuse the existing sbox parameter and are shared with the future decrypt path.
- One sub-module: aes_key_step. It is combinational, takes (roundKey_t rk, byte_t rcon) and returns the next roundKey_t. It is instantiated once.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090A0B0C0D0E0F, plaintext 00112233445566778899AABBCCDDEEFF -> ciphertext 69C4E0D86A7B0430D8CDB78070B4C55A, out_valid exactly 10 cycles after accept.
- FIPS-197 B: key 2B7E151628AED2A6ABF7158809CF4F3C, plaintext 3243F6A8885A308D313198A2E0370734 -> 3925841D02DC09FBDC118597196A0B32. Check round_num steps 1..10.
- Backpressure: hold out_ready=0 for 7 cycles after out_valid -> ciphertext, out_valid and busy stable; one cycle after out_ready=1, the FSM is in IDLE with in_ready=1.
- Busy drop: pulse in_valid with a different block during ROUND -> ignored; only the first block's ciphertext is produced, and the second is accepted only after it is re-presented in IDLE.
- Reset at round 5: drive reset_n=0 asynchronously -> in_ready=1, out_valid=0, round_num=0 without a clock edge. The following C.1 block still produces the correct result.
- Back-to-back: keep in_valid and out_ready high for both vectors -> accepts are 12 cycles apart, and both ciphertexts are correct and in order.

Source files
------------

// File: rtl/aes_encrypt_sequencer_pkg.sv
// Shared AES types, forward S-box, round constants and state-transform helpers.
// Used by the encrypt sequencer and its key-schedule step.
package aes_encrypt_sequencer_pkg;

  typedef logic [7:0] byte_t;
  // Byte 0 is the leftmost (most significant) byte of the 128-bit block.
  typedef byte_t [0:15] state_t;
  typedef byte_t [0:15] roundKey_t;
  typedef byte_t        rcon_t;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} aesSeqState_t;

  localparam byte_t [0:15][0:15] sbox = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam rcon_t [1:10] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic byte_t sboxLookup(input byte_t b);
    return sbox[b[7:4]][b[3:0]];
  endfunction

  // Round counter 0 is only seen outside ROUND; return a harmless constant there.
  function automatic rcon_t getRcon(input logic [3:0] r);
    if (r >= 4'd1 && r <= 4'd10) return RCON[r];
    return 8'h00;
  endfunction

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic state_t subBytes(input state_t s);
    state_t res;
    for (int i = 0; i < 16; i++) res[i] = sboxLookup(s[i]);
    return res;
  endfunction

  function automatic state_t shiftRows(input state_t s);
    state_t res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[r + 4*c] = s[r + 4*((c + r) % 4)];
    return res;
  endfunction

  function automatic state_t mixColumns(input state_t s);
    state_t res;
    byte_t a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[4*c];
      a1 = s[4*c + 1];
      a2 = s[4*c + 2];
      a3 = s[4*c + 3];
      res[4*c]     = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      res[4*c + 1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      res[4*c + 2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      res[4*c + 3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return res;
  endfunction

  function automatic state_t addRoundKey(input state_t s, input roundKey_t k);
    return s ^ k;
  endfunction

endpackage

// File: rtl/aes_encrypt_sequencer_key_step.sv
// Combinational AES-128 key-schedule step: derives the next round key
// from the current one and the round constant.
module aes_key_step
  import aes_encrypt_sequencer_pkg::*;
(
  input  roundKey_t rk,
  input  byte_t     rcon,
  output roundKey_t rk_next
);

  byte_t [0:3] temp;

  // temp = SubWord(RotWord(w3)) ^ {rcon,00,00,00}, then each word chains off the previous one.
  always_comb begin
    temp[0] = sboxLookup(rk[13]) ^ rcon;
    temp[1] = sboxLookup(rk[14]);
    temp[2] = sboxLookup(rk[15]);
    temp[3] = sboxLookup(rk[12]);
    rk_next = '0;
    for (int i = 0; i < 4; i++) begin
      rk_next[i]      = rk[i]      ^ temp[i];
      rk_next[4 + i]  = rk[4 + i]  ^ rk_next[i];
      rk_next[8 + i]  = rk[8 + i]  ^ rk_next[4 + i];
      rk_next[12 + i] = rk[12 + i] ^ rk_next[8 + i];
    end
  end

endmodule

// File: rtl/aes_encrypt_sequencer.sv
// Iterative AES-128 encryption sequencer: one round per clock, with the key
// schedule computed on the fly; valid/ready handshakes on both sides.
module aes_encrypt_sequencer
  import aes_encrypt_sequencer_pkg::*;
#(
  parameter int ROUNDS = 10
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  state_t     plaintext,
  input  roundKey_t  key,
  output logic       out_valid,
  input  logic       out_ready,
  output state_t     ciphertext,
  output logic       busy,
  output logic [3:0] round_num
);

  if (ROUNDS != 10) begin : g_rounds_check
    $error("aes_encrypt_sequencer supports only ROUNDS == 10 (AES-128)");
  end

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);

  aesSeqState_t fsm_state, fsm_next;
  state_t       data_q, data_d, shifted, round_out;
  roundKey_t    rk_q, rk_d, rk_step;
  logic [3:0]   round_q, round_d;
  byte_t        rcon_cur;

  assign rcon_cur = getRcon(round_q);

  aes_key_step u_key_step (
    .rk      (rk_q),
    .rcon    (rcon_cur),
    .rk_next (rk_step)
  );

  // The final round skips MixColumns.
  always_comb begin
    shifted   = shiftRows(subBytes(data_q));
    round_out = addRoundKey((round_q == LAST_ROUND) ? shifted : mixColumns(shifted), rk_step);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm_state <= IDLE;
      data_q    <= '0;
      rk_q      <= '0;
      round_q   <= '0;
    end else begin
      fsm_state <= fsm_next;
      data_q    <= data_d;
      rk_q      <= rk_d;
      round_q   <= round_d;
    end
  end

  // Handshake outputs decode only from fsm_state, so no input-to-output combinational path.
  always_comb begin
    fsm_next  = fsm_state;
    data_d    = data_q;
    rk_d      = rk_q;
    round_d   = round_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (fsm_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d   = addRoundKey(plaintext, key);
          rk_d     = key;
          round_d  = 4'd1;
          fsm_next = ROUND;
        end
      end
      ROUND: begin
        busy   = 1'b1;
        data_d = round_out;
        rk_d   = rk_step;
        if (round_q == LAST_ROUND) fsm_next = DONE;
        else                       round_d  = round_q + 4'd1;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          fsm_next = IDLE;
          round_d  = 4'd0;
        end
      end
      default: fsm_next = IDLE;
    endcase
  end

  assign ciphertext = data_q;
  assign round_num  = round_q;

endmodule

// File: tb/tb_aes_encrypt_sequencer.sv
// Directed self-checking bench for aes_encrypt_sequencer using FIPS-197 vectors.
module tb_aes_encrypt_sequencer;

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] plaintext = '0;
  logic [127:0] key = '0;
  logic         in_ready, out_valid, busy;
  logic [127:0] ciphertext;
  logic [3:0]   round_num;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  aes_encrypt_sequencer #(.ROUNDS(10)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext),
    .busy       (busy),
    .round_num  (round_num)
  );

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task tick();
    @(posedge clock);
    #1;
  endtask

  task automatic accept_block(input logic [127:0] pt, input logic [127:0] k);
    in_valid  = 1'b1;
    plaintext = pt;
    key       = k;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic wait_out(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 30) begin
      tick();
      cycles++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (round_num !== 4'd0) begin errors++; $display("[TB] FAIL rst_round_num: got %0d expected 0", round_num); end
    checks++; if (ciphertext !== 128'h0) begin errors++; $display("[TB] FAIL rst_ciphertext: got %h expected 0", ciphertext); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_fips_c1();
    int cyc;
    accept_block(PT_C1, KEY_C1);
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL c1_busy: got busy=%b in_ready=%b expected 1/0", busy, in_ready); end
    wait_out(cyc);
    checks++; if (cyc !== 10) begin errors++; $display("[TB] FAIL c1_latency: got %0d expected 10", cyc); end
    checks++; if (ciphertext !== CT_C1) begin errors++; $display("[TB] FAIL c1_ciphertext: got %h expected %h", ciphertext, CT_C1); end
    drain();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL c1_return_idle: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
    checks++; if (round_num !== 4'd0) begin errors++; $display("[TB] FAIL c1_round_clear: got %0d expected 0", round_num); end
  endtask

  task automatic test_fips_b();
    accept_block(PT_B, KEY_B);
    checks++; if (round_num !== 4'd1) begin errors++; $display("[TB] FAIL b_round_1: got %0d expected 1", round_num); end
    for (int i = 2; i <= 10; i++) begin
      tick();
      checks++; if (round_num !== 4'(i) || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b_round_step: got %0d/%b expected %0d/0", round_num, out_valid, i); end
    end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL b_out_valid: got %b expected 1", out_valid); end
    checks++; if (ciphertext !== CT_B) begin errors++; $display("[TB] FAIL b_ciphertext: got %h expected %h", ciphertext, CT_B); end
    drain();
  endtask

  task automatic test_backpressure();
    int cyc;
    accept_block(PT_C1, KEY_C1);
    wait_out(cyc);
    checks++; if (cyc !== 10) begin errors++; $display("[TB] FAIL bp_latency: got %0d expected 10", cyc); end
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || busy !== 1'b1 || ciphertext !== CT_C1) begin errors++; $display("[TB] FAIL bp_stall: got valid=%b busy=%b ct=%h expected 1/1/%h", out_valid, busy, ciphertext, CT_C1); end
    end
    drain();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL bp_release: got in_ready=%b valid=%b busy=%b expected 1/0/0", in_ready, out_valid, busy); end
  endtask

  task automatic test_busy_drop();
    int cyc;
    accept_block(PT_C1, KEY_C1);
    repeat (3) tick();
    in_valid  = 1'b1;
    plaintext = PT_B;
    key       = KEY_B;
    repeat (2) tick();
    in_valid  = 1'b0;
    checks++; if (round_num !== 4'd6 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL drop_ignored: got round=%0d in_ready=%b expected 6/0", round_num, in_ready); end
    wait_out(cyc);
    checks++; if (cyc !== 5) begin errors++; $display("[TB] FAIL drop_latency: got %0d expected 5", cyc); end
    checks++; if (ciphertext !== CT_C1) begin errors++; $display("[TB] FAIL drop_first_ct: got %h expected %h", ciphertext, CT_C1); end
    drain();
    accept_block(PT_B, KEY_B);
    wait_out(cyc);
    checks++; if (cyc !== 10 || ciphertext !== CT_B) begin errors++; $display("[TB] FAIL drop_second_ct: got %0d cycles ct=%h expected 10 cycles ct=%h", cyc, ciphertext, CT_B); end
    drain();
  endtask

  task automatic test_reset_mid();
    int cyc;
    int spurious;
    accept_block(PT_C1, KEY_C1);
    repeat (4) tick();
    checks++; if (round_num !== 4'd5) begin errors++; $display("[TB] FAIL mid_round5: got %0d expected 5", round_num); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_async_flags: got in_ready=%b valid=%b busy=%b expected 1/0/0", in_ready, out_valid, busy); end
    checks++; if (round_num !== 4'd0) begin errors++; $display("[TB] FAIL mid_async_round: got %0d expected 0", round_num); end
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    spurious = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) spurious++;
    end
    checks++; if (spurious !== 0) begin errors++; $display("[TB] FAIL mid_no_pulse: got %0d valid cycles expected 0", spurious); end
    accept_block(PT_C1, KEY_C1);
    wait_out(cyc);
    checks++; if (cyc !== 10 || ciphertext !== CT_C1) begin errors++; $display("[TB] FAIL mid_after_ct: got %0d cycles ct=%h expected 10 cycles ct=%h", cyc, ciphertext, CT_C1); end
    drain();
  endtask

  task automatic test_back_to_back();
    int n_acc;
    int n_out;
    int acc_cyc [2];
    logic [127:0] outs [2];
    logic acc, outgo;
    logic [127:0] ct_now;
    n_acc = 0;
    n_out = 0;
    acc_cyc[0] = 0;
    acc_cyc[1] = 0;
    outs[0] = '0;
    outs[1] = '0;
    in_valid  = 1'b1;
    plaintext = PT_C1;
    key       = KEY_C1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && n_out < 2; cyc++) begin
      acc    = in_valid && in_ready;
      outgo  = out_valid && out_ready;
      ct_now = ciphertext;
      tick();
      if (outgo && n_out < 2) begin
        outs[n_out] = ct_now;
        n_out++;
      end
      if (acc && n_acc < 2) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        if (n_acc == 1) begin
          plaintext = PT_B;
          key       = KEY_B;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++; if (n_acc !== 2) begin errors++; $display("[TB] FAIL b2b_accepts: got %0d expected 2", n_acc); end
    checks++; if (acc_cyc[1] - acc_cyc[0] !== 12) begin errors++; $display("[TB] FAIL b2b_period: got %0d expected 12", acc_cyc[1] - acc_cyc[0]); end
    checks++; if (n_out !== 2) begin errors++; $display("[TB] FAIL b2b_outputs: got %0d expected 2", n_out); end
    checks++; if (outs[0] !== CT_C1) begin errors++; $display("[TB] FAIL b2b_first_ct: got %h expected %h", outs[0], CT_C1); end
    checks++; if (outs[1] !== CT_B) begin errors++; $display("[TB] FAIL b2b_second_ct: got %h expected %h", outs[1], CT_B); end
  endtask

  initial begin
    $display("[TB] starting aes_encrypt_sequencer bench");
    test_reset();
    test_fips_c1();
    test_fips_b();
    test_backpressure();
    test_busy_drop();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
